// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state types and defaults for the ALU sequencer
package alu_pkg;

    localparam int ALU_DATA_W = 8;

    typedef enum logic [3:0] {
        OP_PASS_B = 4'd0,
        OP_PASS_A = 4'd1,
        OP_ADD    = 4'd2,
        OP_SUB    = 4'd3,
        OP_AND    = 4'd4,
        OP_INC    = 4'd5,
        OP_DEC    = 4'd6,
        OP_XOR    = 4'd7,
        OP_NOP    = 4'd8,
        OP_CLEAR  = 4'd9,
        OP_OR     = 4'd10,
        OP_SWAP   = 4'd11,
        OP_CMPL   = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_e;

    // Opcodes 13-15 have no ALU meaning and are reported as errors.
    function automatic logic op_undefined(input logic [3:0] op);
        return op > 4'(OP_CMPL);
    endfunction

    function automatic logic op_uses_alu(input logic [3:0] op);
        return (op != 4'(OP_NOP)) && !op_undefined(op);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - single-command sequencer driving an external combinational ALU
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_operand,
    output logic              cmd_ready,
    output logic [3:0]        alu_inst,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W:0]   alu_ans,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_acc,
    output logic              res_carry,
    output logic              res_err
);

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] opd_q;
    logic [DATA_W-1:0] acc_q;
    logic              carry_q;
    logic              err_q;
    logic              accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        accept    = 1'b0;
        alu_inst  = 4'(OP_NOP);
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    // nop and undefined opcodes skip the ALU and answer at once
                    state_d = op_uses_alu(cmd_op) ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                alu_inst = op_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= 4'(OP_NOP);
            opd_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= cmd_op;
                opd_q <= cmd_operand;
                err_q <= op_undefined(cmd_op);
            end
            if (state_q == ST_ISSUE) begin
                acc_q   <= alu_ans[DATA_W-1:0];
                carry_q <= alu_ans[DATA_W];
            end
        end
    end

    assign alu_a     = opd_q;
    assign alu_b     = acc_q;
    assign res_acc   = acc_q;
    assign res_carry = carry_q;
    assign res_err   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed table-driven bench for alu_sequencer with an ALU model beside it
module tb_alu_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic [3:0] cmd_op;
    logic [7:0] cmd_operand;
    logic       cmd_ready;
    logic [3:0] alu_inst;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [8:0] alu_ans;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_acc;
    logic       res_carry;
    logic       res_err;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .cmd_ready   (cmd_ready),
        .alu_inst    (alu_inst),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ans     (alu_ans),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_acc     (res_acc),
        .res_carry   (res_carry),
        .res_err     (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU sitting beside the sequencer, as the parent would place it.
    always_comb begin
        alu_ans = {1'b0, alu_b};
        case (alu_inst)
            4'd0:  alu_ans = {1'b0, alu_b};
            4'd1:  alu_ans = {1'b0, alu_a};
            4'd2:  alu_ans = {1'b0, alu_a} + {1'b0, alu_b};
            4'd3:  alu_ans = {1'b0, alu_b} - {1'b0, alu_a};
            4'd4:  alu_ans = {1'b0, alu_a & alu_b};
            4'd5:  alu_ans = {1'b0, alu_b} + 9'd1;
            4'd6:  alu_ans = {1'b0, alu_b} - 9'd1;
            4'd7:  alu_ans = {1'b0, alu_a ^ alu_b};
            4'd9:  alu_ans = 9'd0;
            4'd10: alu_ans = {1'b0, alu_a | alu_b};
            4'd11: alu_ans = {1'b0, alu_b[3:0], alu_b[7:4]};
            4'd12: alu_ans = {1'b0, ~alu_b};
            default: alu_ans = {1'b0, alu_b};
        endcase
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] opd;
        logic [7:0] acc;
        logic       carry;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge with the sequencer idle; completes the handshake.
    task automatic do_cmd(input vec_t v, input string nm);
        int lat;
        chk({nm, " cmd_ready idle"}, cmd_ready, 1);
        chk({nm, " alu_inst idle"}, alu_inst, 4'd8);
        cmd_valid   = 1'b1;
        cmd_op      = v.op;
        cmd_operand = v.opd;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
        cmd_op      = ~v.op;
        cmd_operand = ~v.opd;
        lat = 1;
        if (v.lat == 2) begin
            chk({nm, " alu_inst issue"}, alu_inst, v.op);
            chk({nm, " alu_a issue"}, alu_a, v.opd);
            chk({nm, " cmd_ready issue"}, cmd_ready, 0);
        end
        while (!res_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, v.lat);
        chk({nm, " res_acc"}, res_acc, v.acc);
        chk({nm, " res_carry"}, res_carry, v.carry);
        chk({nm, " res_err"}, res_err, v.err);
        chk({nm, " alu_inst resp"}, alu_inst, 4'd8);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk({nm, " res_valid drop"}, res_valid, 0);
    endtask

    initial begin
        vec_t v;
        logic [7:0] held_acc;
        reset       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 4'd0;
        cmd_operand = 8'd0;
        res_ready   = 1'b0;

        // op, operand, acc, carry, err, latency
        vecs.push_back('{4'd1,  8'h5A, 8'h5A, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd0,  8'h77, 8'h5A, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd2,  8'hB0, 8'h0A, 1'b1, 1'b0, 2});
        vecs.push_back('{4'd3,  8'h0B, 8'hFF, 1'b1, 1'b0, 2});
        vecs.push_back('{4'd5,  8'h00, 8'h00, 1'b1, 1'b0, 2});
        vecs.push_back('{4'd6,  8'h00, 8'hFF, 1'b1, 1'b0, 2});
        vecs.push_back('{4'd8,  8'h12, 8'hFF, 1'b1, 1'b0, 1});
        vecs.push_back('{4'd15, 8'h34, 8'hFF, 1'b1, 1'b1, 1});
        vecs.push_back('{4'd4,  8'h0F, 8'h0F, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd7,  8'h33, 8'h3C, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd11, 8'h00, 8'hC3, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd12, 8'h00, 8'h3C, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd10, 8'h81, 8'hBD, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd9,  8'h55, 8'h00, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd1,  8'h21, 8'h21, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd14, 8'h99, 8'h21, 1'b0, 1'b1, 1});
        vecs.push_back('{4'd8,  8'h99, 8'h21, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd13, 8'h01, 8'h21, 1'b0, 1'b1, 1});
        vecs.push_back('{4'd0,  8'h00, 8'h21, 1'b0, 1'b0, 2});

        #12;
        chk("reset res_valid", res_valid, 0);
        chk("reset res_acc", res_acc, 0);
        chk("reset res_carry", res_carry, 0);
        chk("reset res_err", res_err, 0);
        chk("reset alu_inst", alu_inst, 4'd8);
        chk("reset alu_a", alu_a, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset cmd_ready", cmd_ready, 1);

        foreach (vecs[i]) begin
            do_cmd(vecs[i], $sformatf("vec%0d", i));
        end

        // Spurious res_ready while idle must not disturb anything.
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("idle res_ready res_valid", res_valid, 0);
        chk("idle res_ready cmd_ready", cmd_ready, 1);

        // Backpressure: result held five cycles while a second command waits.
        cmd_valid   = 1'b1;
        cmd_op      = 4'd2;
        cmd_operand = 8'h10;
        @(posedge clk); #1;
        cmd_op      = 4'd9;
        cmd_operand = 8'hEE;
        @(posedge clk); #1;
        chk("bp res_valid", res_valid, 1);
        held_acc = res_acc;
        chk("bp res_acc", held_acc, 8'h31);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d res_valid", k), res_valid, 1);
            chk($sformatf("bp hold%0d res_acc", k), res_acc, held_acc);
            chk($sformatf("bp hold%0d cmd_ready", k), cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("bp release res_valid", res_valid, 0);
        chk("bp release cmd_ready", cmd_ready, 1);
        chk("bp release res_acc", res_acc, 8'h31);

        // Reset during ISSUE aborts the command.
        cmd_valid   = 1'b1;
        cmd_op      = 4'd5;
        cmd_operand = 8'h00;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("abort in issue", alu_inst, 4'd5);
        reset = 1'b0;
        #1;
        chk("abort alu_inst", alu_inst, 4'd8);
        chk("abort res_acc", res_acc, 0);
        chk("abort res_valid", res_valid, 0);
        chk("abort res_carry", res_carry, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("abort quiet%0d res_valid", k), res_valid, 0);
        end
        v = '{4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 2};
        do_cmd(v, "post_abort");

        // Reset during RESP also discards the result.
        v = '{4'd1, 8'h44, 8'h44, 1'b0, 1'b0, 2};
        cmd_valid   = 1'b1;
        cmd_op      = v.op;
        cmd_operand = v.opd;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("resp abort pre", res_valid, 1);
        reset = 1'b0;
        #1;
        chk("resp abort res_valid", res_valid, 0);
        chk("resp abort res_acc", res_acc, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("resp abort after", res_valid, 0);
        chk("resp abort cmd_ready", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
